// File: rtl/alu_ops_pkg.sv
// Shared ALU function codes, multiplier FSM encoding and an op-class helper.
// Latency: n/a (declarations only).
// Backpressure: n/a. Imported by the ALU control stage and by alu_hilo/mul_seq.
package alu_ops_pkg;

    // Function codes carried on ALUOperation
    localparam logic [5:0] F_add   = 6'd32;
    localparam logic [5:0] F_sub   = 6'd34;
    localparam logic [5:0] F_and   = 6'd36;
    localparam logic [5:0] F_or    = 6'd37;
    localparam logic [5:0] F_slt   = 6'd42;
    localparam logic [5:0] F_multu = 6'd25;
    localparam logic [5:0] F_mfhi  = 6'd16;
    localparam logic [5:0] F_mflo  = 6'd18;

    // Multiplier FSM states
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mul_state_e;

    // Ops that touch HI/LO and must wait for an in-flight multiply
    function automatic logic is_hilo_op(input logic [5:0] op);
        return (op == F_multu) || (op == F_mfhi) || (op == F_mflo);
    endfunction

endpackage

// File: rtl/alu_hilo_if.sv
// EX-stage ALU bus: operation/operands in, result/zero/stall/busy out.
// Latency: n/a (wires only).
// Backpressure: stall is the only hold signal; master keeps op/a/b stable while it is high.
// master: EX stage driver; slave: alu_hilo.
interface alu_hilo_if #(parameter int WIDTH = 32);
    logic             op_valid;
    logic [5:0]       ALUOperation;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             stall;
    logic             mul_busy;

    modport master (
        output op_valid, ALUOperation, a, b,
        input  result, zero, stall, mul_busy
    );

    modport slave (
        input  op_valid, ALUOperation, a, b,
        output result, zero, stall, mul_busy
    );
endinterface

// File: rtl/mul_seq.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// Latency: WIDTH cycles in BUSY after the start edge; done marks the final BUSY cycle.
// Backpressure: start is ignored while busy; the caller holds off further requests.
// Ports: clk, rst_n, start, a (mcand), b (mplier) in; busy, done, hi, lo out.
// hi/lo carry the final product combinationally during the done cycle.
module mul_seq
    import alu_ops_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mul_state_e           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   acc_step;
    logic [WIDTH:0]       upper_sum;

    // One iteration: conditional add into the upper half, keeping the carry,
    // then the {carry, acc} shift right by one.
    always_comb begin
        upper_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};
        acc_step  = {upper_sum, acc_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = a;
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                acc_d    = acc_step;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    assign busy = (state_q == BUSY);
    assign done = busy && (cnt_q == LAST);
    assign hi   = acc_step[2*WIDTH-1:WIDTH];
    assign lo   = acc_step[WIDTH-1:0];

endmodule

// File: rtl/alu_hilo.sv
// EX-stage ALU: combinational add/sub/and/or/slt, HI/LO registers fed by mul_seq.
// Latency: single-cycle ops combinational; multu result in HI/LO WIDTH+1 cycles after issue.
// Backpressure: stall raised while the multiplier is busy and multu/mfhi/mflo is presented.
// Ports: clk, rst_n, bus (alu_hilo_if.slave: op_valid, ALUOperation, a, b -> result, zero,
// stall, mul_busy).
module alu_hilo
    import alu_ops_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_hilo_if.slave  bus
);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    logic             mul_start, mul_done, mul_busy, stall;

    assign stall     = mul_busy & bus.op_valid & is_hilo_op(bus.ALUOperation);
    assign mul_start = ~mul_busy & bus.op_valid & (bus.ALUOperation == F_multu) & ~stall;

    mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (bus.a),
        .b     (bus.b),
        .busy  (mul_busy),
        .done  (mul_done),
        .hi    (mul_hi),
        .lo    (mul_lo)
    );

    // Stalled or bubble cycles present 0 so nothing downstream sees stale HI/LO.
    always_comb begin
        alu_res = '0;
        if (bus.op_valid && !stall) begin
            case (bus.ALUOperation)
                F_add:   alu_res = bus.a + bus.b;
                F_sub:   alu_res = bus.a - bus.b;
                F_and:   alu_res = bus.a & bus.b;
                F_or:    alu_res = bus.a | bus.b;
                F_slt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
                F_mfhi:  alu_res = hi_q;
                F_mflo:  alu_res = lo_q;
                default: alu_res = '0;
            endcase
        end
    end

    // HI/LO load only on the final multiplier edge, so an abandoned multiply leaves them alone.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (mul_done) begin
            hi_d = mul_hi;
            lo_d = mul_lo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign bus.result   = alu_res;
    assign bus.zero     = (alu_res == '0);
    assign bus.stall    = stall;
    assign bus.mul_busy = mul_busy;

endmodule

// File: tb/tb_alu_hilo.sv
// Self-checking bench for alu_hilo: directed cases plus randomized ops against a
// cycle-count reference model (64-bit product, BUSY window length, HI/LO shadow).
// Inputs change 1ns after the rising edge; outputs are checked 4ns after it.
module tb_alu_hilo;

    localparam logic [5:0] OP_ADD = 6'd32, OP_SUB = 6'd34, OP_AND = 6'd36, OP_OR = 6'd37,
                           OP_SLT = 6'd42, OP_MULTU = 6'd25, OP_MFHI = 6'd16, OP_MFLO = 6'd18;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_hilo_if #(.WIDTH(32)) bus ();

    alu_hilo #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // Reference state
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int          rem = 0;      // remaining BUSY cycles including the current one
    logic        last_stall = 1'b0;

    function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] x,
                                            input logic [31:0] y, input logic [31:0] h,
                                            input logic [31:0] l);
        case (op)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_SLT:  return (int'(x) < int'(y)) ? 32'd1 : 32'd0;
            OP_MFHI: return h;
            OP_MFLO: return l;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] x,
                         input logic [31:0] y);
        bus.op_valid     = v;
        bus.ALUOperation = op;
        bus.a            = x;
        bus.b            = y;
    endtask

    // One cycle: check outputs against the model, take the edge, advance the model.
    // has_c adds a hand-computed constant check of result and stall.
    task automatic tick(input string tag, input bit has_c = 1'b0,
                        input logic [31:0] c_res = '0, input logic c_stall = 1'b0);
        logic        lv, eb, es;
        logic [5:0]  lop;
        logic [31:0] la, lb, er;
        logic [63:0] prod;
        #3;
        lv = bus.op_valid; lop = bus.ALUOperation; la = bus.a; lb = bus.b;
        eb = (rem > 0);
        es = eb && lv && (lop == OP_MULTU || lop == OP_MFHI || lop == OP_MFLO);
        er = (!lv || es) ? 32'd0 : ref_alu(lop, la, lb, m_hi, m_lo);
        chk({tag, " result"}, bus.result, er);
        chk({tag, " zero"}, {31'd0, bus.zero}, {31'd0, (er == 32'd0)});
        chk({tag, " stall"}, {31'd0, bus.stall}, {31'd0, es});
        chk({tag, " mul_busy"}, {31'd0, bus.mul_busy}, {31'd0, eb});
        if (has_c) begin
            chk({tag, " const_result"}, bus.result, c_res);
            chk({tag, " const_stall"}, {31'd0, bus.stall}, {31'd0, c_stall});
        end
        last_stall = es;
        @(posedge clk);
        if (rem > 0) begin
            rem--;
            if (rem == 0) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (lv && lop == OP_MULTU) begin
            prod = {32'd0, la} * {32'd0, lb};
            p_hi = prod[63:32];
            p_lo = prod[31:0];
            rem  = 32;
        end
        #1;
    endtask

    logic [5:0]  ops [10] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MULTU,
                              OP_MFHI, OP_MFLO, 6'd63, 6'd0};

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        drive(1'b1, OP_MFHI, 32'd0, 32'd0);
        #12;
        // Reset state
        chk("reset mul_busy", {31'd0, bus.mul_busy}, 32'd0);
        chk("reset stall", {31'd0, bus.stall}, 32'd0);
        chk("reset mfhi", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-cycle ops
        drive(1, OP_ADD, 32'h7FFF_FFFF, 32'd1); tick("add ovf", 1, 32'h8000_0000, 0);
        drive(1, OP_SUB, 32'd5, 32'd5);         tick("sub zero", 1, 32'd0, 0);
        drive(1, OP_SLT, 32'hFFFF_FFFF, 32'd1); tick("slt neg", 1, 32'd1, 0);
        drive(1, OP_SLT, 32'd1, 32'hFFFF_FFFF); tick("slt pos", 1, 32'd0, 0);
        drive(1, OP_AND, 32'hF0F0, 32'h0FF0);   tick("and", 1, 32'h00F0, 0);
        drive(1, OP_OR, 32'hF0F0, 32'h0FF0);    tick("or", 1, 32'hFFF0, 0);
        drive(1, 6'd63, 32'h1234, 32'h5678);    tick("bad code", 1, 32'd0, 0);
        drive(0, OP_ADD, 32'h1234, 32'h5678);   tick("bubble", 1, 32'd0, 0);

        // All-ones squared, mfhi waits behind it
        drive(1, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); tick("ff multu c0", 1, 32'd0, 0);
        for (int i = 1; i <= 32; i++) begin
            drive(1, OP_MFHI, 32'd0, 32'd0); tick("ff mfhi stalled", 1, 32'd0, 1);
        end
        drive(1, OP_MFHI, 32'd0, 32'd0); tick("ff mfhi c33", 1, 32'hFFFF_FFFE, 0);
        drive(1, OP_MFLO, 32'd0, 32'd0); tick("ff mflo", 1, 32'd1, 0);

        // Reset in the middle of a multiply
        drive(1, OP_MULTU, 32'hDEAD_BEEF, 32'h0001_2345); tick("rst multu c0");
        for (int i = 1; i <= 9; i++) begin
            drive(1, OP_ADD, i, 32'd1); tick("rst busy add");
        end
        drive(1, OP_ADD, 32'd1, 32'd2);
        #2; rst_n = 1'b0; #1;
        chk("rst async mul_busy", {31'd0, bus.mul_busy}, 32'd0);
        chk("rst async stall", {31'd0, bus.stall}, 32'd0);
        chk("rst async add", bus.result, 32'd3);
        drive(1, OP_MFHI, 32'd0, 32'd0); #1;
        chk("rst async hi", bus.result, 32'd0);
        drive(1, OP_MFLO, 32'd0, 32'd0); #1;
        chk("rst async lo", bus.result, 32'd0);
        rem = 0; m_hi = '0; m_lo = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1, OP_MFHI, 32'd0, 32'd0); tick("post rst mfhi", 1, 32'd0, 0);
        drive(1, OP_MFLO, 32'd0, 32'd0); tick("post rst mflo", 1, 32'd0, 0);

        // 2^16 squared, then zero times something
        drive(1, OP_MULTU, 32'h0001_0000, 32'h0001_0000); tick("p16 multu");
        for (int i = 0; i < 32; i++) begin
            drive(0, OP_ADD, 32'd0, 32'd0); tick("p16 wait");
        end
        drive(1, OP_MFHI, 32'd0, 32'd0); tick("p16 hi", 1, 32'd1, 0);
        drive(1, OP_MFLO, 32'd0, 32'd0); tick("p16 lo", 1, 32'd0, 0);
        drive(1, OP_MULTU, 32'd0, 32'h1234_5678); tick("zero multu");
        for (int i = 0; i < 32; i++) begin
            drive(0, OP_ADD, 32'd0, 32'd0); tick("zero wait");
        end
        drive(1, OP_MFHI, 32'd0, 32'd0); tick("zero hi", 1, 32'd0, 0);
        drive(1, OP_MFLO, 32'd0, 32'd0); tick("zero lo", 1, 32'd0, 0);

        // Back-to-back multu
        drive(1, OP_MULTU, 32'd3, 32'd4); tick("b2b first", 1, 32'd0, 0);
        for (int i = 1; i <= 32; i++) begin
            drive(1, OP_MULTU, 32'd5, 32'd6); tick("b2b second stalled", 1, 32'd0, 1);
        end
        drive(1, OP_MULTU, 32'd5, 32'd6); tick("b2b second start c33", 1, 32'd0, 0);
        for (int i = 0; i < 32; i++) begin
            drive(1, OP_MFLO, 32'd0, 32'd0); tick("b2b mflo stalled", 1, 32'd0, 1);
        end
        drive(1, OP_MFLO, 32'd0, 32'd0); tick("b2b lo", 1, 32'd30, 0);
        drive(1, OP_MFHI, 32'd0, 32'd0); tick("b2b hi", 1, 32'd0, 0);

        // Independent ops and bubbles during BUSY
        drive(1, OP_MULTU, 32'd7, 32'd9); tick("ind multu");
        for (int i = 1; i <= 32; i++) begin
            logic [31:0] x, y;
            x = $urandom; y = $urandom;
            if (i % 2 == 0) begin
                drive(0, OP_ADD, x, y); tick("ind bubble", 1, 32'd0, 0);
            end else begin
                drive(1, OP_ADD, x, y); tick("ind add", 1, x + y, 0);
            end
        end
        drive(1, OP_MFLO, 32'd0, 32'd0); tick("ind lo c33", 1, 32'd63, 0);

        // Randomized mix; inputs held while stalled
        for (int i = 0; i < 400; i++) begin
            if (!last_stall) begin
                drive(($urandom_range(0, 3) != 0), ops[$urandom_range(0, 9)],
                      rnd_operand(), rnd_operand());
            end
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety bound: the sequence above is a few thousand cycles.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
